register_file_rename: RTL

- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer's commit port and beside the dispatcher.
- Holds 32 x 32-bit values, each with a 6-bit ROB tag (0 = no pending producer).
- The dispatcher reads source operands (value or tag) and renames destinations on issue. The reorder buffer retires results into it, and its rollback flushes all tags.

---
 rtl/register_file_rename.sv | 120 ++++++++++++
 1 files changed

// File: rtl/register_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Combinational operand reads with commit bypass; commit, issue and rollback update on clk_in.
module register_file_rename #(
   parameter int unsigned REG_NUM  = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ROB_ID_W = 6
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       rdy_in,
   input  logic [$clog2(REG_NUM)-1:0] rs1_from_dispatcher,
   input  logic [$clog2(REG_NUM)-1:0] rs2_from_dispatcher,
   output logic [DATA_W-1:0]          V1_to_dispatcher,
   output logic [ROB_ID_W-1:0]        Q1_to_dispatcher,
   output logic [DATA_W-1:0]          V2_to_dispatcher,
   output logic [ROB_ID_W-1:0]        Q2_to_dispatcher,
   input  logic                       enable_from_dispatcher,
   input  logic [$clog2(REG_NUM)-1:0] rd_from_dispatcher,
   input  logic [ROB_ID_W-1:0]        rob_id_from_dispatcher,
   input  logic                       commit_flag,
   input  logic [$clog2(REG_NUM)-1:0] rd_from_rob,
   input  logic [DATA_W-1:0]          V_from_rob,
   input  logic [ROB_ID_W-1:0]        Q_from_rob,
   input  logic                       rollback_flag,
   output logic [31:0]                commit_count_out
);

   localparam int unsigned IDX_W = $clog2(REG_NUM);
   localparam int unsigned CNT_W = 32;

   logic [DATA_W-1:0]   value_q [REG_NUM];
   logic [DATA_W-1:0]   value_d [REG_NUM];
   logic [ROB_ID_W-1:0] tag_q   [REG_NUM];
   logic [ROB_ID_W-1:0] tag_d   [REG_NUM];
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;

   logic commit_wr_c;
   logic issue_wr_c;
   logic hit1_c;
   logic hit2_c;

   assign commit_wr_c = commit_flag && (rd_from_rob != IDX_W'(0));
   assign issue_wr_c  = enable_from_dispatcher && !rollback_flag
                        && (rd_from_dispatcher != IDX_W'(0));

   // Bypass only when the committing entry is the register's current producer.
   assign hit1_c = (tag_q[rs1_from_dispatcher] != ROB_ID_W'(0)) && commit_flag
                   && (rd_from_rob == rs1_from_dispatcher)
                   && (Q_from_rob == tag_q[rs1_from_dispatcher]);
   assign hit2_c = (tag_q[rs2_from_dispatcher] != ROB_ID_W'(0)) && commit_flag
                   && (rd_from_rob == rs2_from_dispatcher)
                   && (Q_from_rob == tag_q[rs2_from_dispatcher]);

   always_comb begin
      V1_to_dispatcher = value_q[rs1_from_dispatcher];
      Q1_to_dispatcher = tag_q[rs1_from_dispatcher];
      if (rs1_from_dispatcher == IDX_W'(0)) begin
         V1_to_dispatcher = '0;
         Q1_to_dispatcher = '0;
      end else if (hit1_c) begin
         V1_to_dispatcher = V_from_rob;
         Q1_to_dispatcher = '0;
      end
   end

   always_comb begin
      V2_to_dispatcher = value_q[rs2_from_dispatcher];
      Q2_to_dispatcher = tag_q[rs2_from_dispatcher];
      if (rs2_from_dispatcher == IDX_W'(0)) begin
         V2_to_dispatcher = '0;
         Q2_to_dispatcher = '0;
      end else if (hit2_c) begin
         V2_to_dispatcher = V_from_rob;
         Q2_to_dispatcher = '0;
      end
   end

   // Next state: commit first, then rollback/issue so issue overrides a tag clear.
   always_comb begin
      value_d = value_q;
      tag_d   = tag_q;
      count_d = count_q;
      if (rdy_in) begin
         if (commit_flag) begin
            count_d = count_q + CNT_W'(1);
         end
         if (commit_wr_c) begin
            value_d[rd_from_rob] = V_from_rob;
            if (tag_q[rd_from_rob] == Q_from_rob) begin
               tag_d[rd_from_rob] = '0;
            end
         end
         if (rollback_flag) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
               tag_d[i] = '0;
            end
         end else if (issue_wr_c) begin
            tag_d[rd_from_dispatcher] = rob_id_from_dispatcher;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < int'(REG_NUM); i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         count_q <= '0;
      end else begin
         value_q <= value_d;
         tag_q   <= tag_d;
         count_q <= count_d;
      end
   end

   assign commit_count_out = count_q;

endmodule
